sblk_inst_sched: RTL and testbench

SBLK_INST_SCHED -- requirements
Module: sblk_inst_sched

---
 rtl/sblk_inst_sched.sv | 160 ++++++++++++++++
 tb/tb_sblk_inst_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sblk_inst_sched.sv
// Superblock instruction scheduler: queues row-masked commands and issues them in
// order once their target rows are idle, with a guard gap between issues.

module sblk_row_drv #(
  parameter int WID_INST = 14
) (
  input  logic                clk_l,
  input  logic                rst,
  input  logic                issue,
  input  logic                sel,
  input  logic [WID_INST-1:0] inst,
  output logic [WID_INST-1:0] data,
  output logic                en
);
  // Unselected rows keep their last instruction on the bus.
  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      data <= '0;
      en   <= 1'b0;
    end else begin
      en <= issue & sel;
      if (issue && sel) data <= inst;
    end
  end
endmodule

module sblk_inst_sched #(
  parameter int N_ROW      = 6,
  parameter int WID_INST   = 14,
  parameter int FIFO_DEPTH = 4,
  parameter int GUARD_CYC  = 2
) (
  input  logic                      clk_l,
  input  logic                      rst,
  input  logic [WID_INST-1:0]       cmd_inst,
  input  logic [N_ROW-1:0]          cmd_mask,
  input  logic                      cmd_sync,
  input  logic                      cmd_vld,
  output logic                      cmd_rdy,
  input  logic [N_ROW-1:0]          status_sblk,
  output logic [WID_INST*N_ROW-1:0] inst_data,
  output logic [N_ROW-1:0]          inst_en,
  output logic                      busy,
  output logic                      err_mask_zero
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GLAST   = GW'(GUARD_CYC - 1);

  typedef struct packed {
    logic                sync;
    logic [N_ROW-1:0]    mask;
    logic [WID_INST-1:0] inst;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, GUARD} state_t;

  cmd_t                mem [FIFO_DEPTH];
  cmd_t                head;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                rdy_ok;
  logic                push, pop, load, err_set, issue;
  state_t              state, nxt;
  logic [GW-1:0]       gcnt;
  logic [N_ROW-1:0]    cur_mask;
  logic [WID_INST-1:0] cur_inst;

  // Ready comes only from registers; rdy_ok keeps it low until the first edge after reset.
  assign cmd_rdy = rdy_ok && (count < DEPTH_C);
  assign push    = cmd_vld && cmd_rdy;
  assign head    = mem[rd_ptr];
  assign issue   = (state == ISSUE);

  always_ff @(posedge clk_l) begin
    if (push) mem[wr_ptr] <= {cmd_sync, cmd_mask, cmd_inst};
  end

  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdy_ok <= 1'b0;
    end else begin
      rdy_ok <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Only the head is ever considered, so a blocked head stalls everything behind it.
  always_comb begin
    nxt     = state;
    pop     = 1'b0;
    load    = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          if (head.sync) begin
            if (status_sblk == '0) pop = 1'b1;
          end else if (head.mask == '0) begin
            pop     = 1'b1;
            err_set = 1'b1;
          end else if ((status_sblk & head.mask) == '0) begin
            pop  = 1'b1;
            load = 1'b1;
            nxt  = ISSUE;
          end
        end
      end
      ISSUE:   nxt = GUARD;
      GUARD:   if (gcnt == GLAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_l or posedge rst) begin
    if (rst) begin
      gcnt          <= '0;
      cur_mask      <= '0;
      cur_inst      <= '0;
      busy          <= 1'b0;
      err_mask_zero <= 1'b0;
    end else begin
      gcnt          <= (state == GUARD) ? gcnt + GW'(1) : '0;
      err_mask_zero <= err_set;
      busy          <= (count != '0) || (state != IDLE) || (status_sblk != '0);
      if (load) begin
        cur_mask <= head.mask;
        cur_inst <= head.inst;
      end
    end
  end

  for (genvar i = 0; i < N_ROW; i++) begin : g_row
    sblk_row_drv #(.WID_INST(WID_INST)) u_row (
      .clk_l (clk_l),
      .rst   (rst),
      .issue (issue),
      .sel   (cur_mask[i]),
      .inst  (cur_inst),
      .data  (inst_data[i*WID_INST +: WID_INST]),
      .en    (inst_en[i])
    );
  end
endmodule

// File: tb/tb_sblk_inst_sched.sv
// Scoreboard bench for sblk_inst_sched: directed commands push expected issues,
// a negedge monitor pops and compares every inst_en / err_mask_zero pulse.

module tb_sblk_inst_sched;
  localparam int NR = 6;
  localparam int WI = 14;
  localparam int GC = 2;

  logic             clk_l = 1'b0;
  logic             rst = 1'b1;
  logic [WI-1:0]    cmd_inst = '0;
  logic [NR-1:0]    cmd_mask = '0;
  logic             cmd_sync = 1'b0;
  logic             cmd_vld = 1'b0;
  logic             cmd_rdy;
  logic [NR-1:0]    status_sblk = '0;
  logic [WI*NR-1:0] inst_data;
  logic [NR-1:0]    inst_en;
  logic             busy;
  logic             err_mask_zero;

  sblk_inst_sched #(.N_ROW(NR), .WID_INST(WI), .FIFO_DEPTH(4), .GUARD_CYC(GC)) dut (
    .clk_l(clk_l), .rst(rst), .cmd_inst(cmd_inst), .cmd_mask(cmd_mask),
    .cmd_sync(cmd_sync), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .status_sblk(status_sblk), .inst_data(inst_data), .inst_en(inst_en),
    .busy(busy), .err_mask_zero(err_mask_zero)
  );

  always #5 clk_l = ~clk_l;

  int cyc = 0;
  always @(posedge clk_l) cyc <= cyc + 1;

  typedef struct {
    logic [NR-1:0]    mask;
    logic [WI*NR-1:0] data;
    int               exact;
  } iss_t;

  iss_t             iss_q[$];
  int               err_q[$];
  logic [WI*NR-1:0] model = '0;
  int               nchk = 0;
  int               nerr = 0;
  int               last_iss = -1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_l);
      #1;
    end
  endtask

  task automatic expect_issue(input logic [NR-1:0] m, input logic [WI-1:0] inst, input int ex);
    iss_t e;
    for (int r = 0; r < NR; r++) if (m[r]) model[r*WI +: WI] = inst;
    e.mask = m;
    e.data = model;
    e.exact = ex;
    iss_q.push_back(e);
  endtask

  // Returns the cycle number of the accepting edge.
  task automatic send(input logic s, input logic [NR-1:0] m, input logic [WI-1:0] inst, output int k);
    int t;
    t = 0;
    k = -1;
    cmd_sync = s; cmd_mask = m; cmd_inst = inst; cmd_vld = 1'b1;
    while (!cmd_rdy && t < 200) begin
      tick(1);
      t++;
    end
    if (!cmd_rdy) begin
      nchk++; nerr++;
      $display("FAIL send_timeout: got rdy=0 want rdy=1 within 200 cycles");
      cmd_vld = 1'b0;
    end else begin
      @(posedge clk_l);
      #1;
      k = cyc;
      cmd_vld = 1'b0;
    end
  endtask

  always @(negedge clk_l) begin
    if (!rst) begin
      if (inst_en != '0) begin
        if (last_iss >= 0) chk("issue_spacing_ok", 128'((cyc - last_iss) >= GC + 1), 128'd1);
        last_iss = cyc;
        if (iss_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_issue: got en=%b want none (cyc %0d)", inst_en, cyc);
        end else begin
          iss_t e;
          e = iss_q.pop_front();
          chk("issue_mask", 128'(inst_en), 128'(e.mask));
          chk("issue_data", 128'(inst_data), 128'(e.data));
          if (e.exact >= 0) chk("issue_cycle", 128'(cyc), 128'(e.exact));
        end
      end
      if (err_mask_zero) begin
        if (err_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL unexpected_err: got err_mask_zero=1 want 0 (cyc %0d)", cyc);
        end else begin
          chk("err_cycle", 128'(cyc), 128'(err_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, e, r, t;

    // reset state
    tick(2);
    chk("rst_inst_en", 128'(inst_en), 128'd0);
    chk("rst_inst_data", 128'(inst_data), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_err", 128'(err_mask_zero), 128'd0);
    chk("rst_cmd_rdy", 128'(cmd_rdy), 128'd0);
    rst = 1'b0;
    chk("rdy_before_edge", 128'(cmd_rdy), 128'd0);
    tick(1);
    chk("rdy_after_edge", 128'(cmd_rdy), 128'd1);

    // basic issue with exact latency
    send(1'b0, 6'b000101, 14'h1A5, k);
    expect_issue(6'b000101, 14'h1A5, k + 2);
    tick(8);
    chk("busy_idle", 128'(busy), 128'd0);

    // busy row blocks issue until it drops
    status_sblk = 6'b000100;
    send(1'b0, 6'b000100, 14'h02B, k);
    tick(6);
    chk("busy_blocked", 128'(busy), 128'd1);
    status_sblk = '0;
    e = cyc;
    expect_issue(6'b000100, 14'h02B, e + 2);
    tick(1);
    chk("busy_release", 128'(busy), 128'd1);
    tick(8);

    // full fifo, held 5th command, in-order drain at a fixed cadence
    status_sblk = 6'b111111;
    send(1'b0, 6'b000001, 14'h011, k);
    send(1'b0, 6'b000010, 14'h022, k);
    send(1'b0, 6'b000100, 14'h033, k);
    send(1'b0, 6'b001000, 14'h044, k);
    chk("full_rdy_low", 128'(cmd_rdy), 128'd0);
    cmd_sync = 1'b0; cmd_mask = 6'b010000; cmd_inst = 14'h055; cmd_vld = 1'b1;
    tick(3);
    chk("full_held", 128'(cmd_rdy), 128'd0);
    chk("full_busy", 128'(busy), 128'd1);
    status_sblk = '0;
    r = cyc;
    expect_issue(6'b000001, 14'h011, r + 2);
    expect_issue(6'b000010, 14'h022, r + 6);
    expect_issue(6'b000100, 14'h033, r + 10);
    expect_issue(6'b001000, 14'h044, r + 14);
    expect_issue(6'b010000, 14'h055, r + 18);
    send(1'b0, 6'b010000, 14'h055, k);
    chk("full_5th_accept", 128'(k), 128'(r + 2));
    tick(24);

    // barrier holds B until every row is idle
    send(1'b0, 6'b000001, 14'h00A, k);
    expect_issue(6'b000001, 14'h00A, k + 2);
    send(1'b1, 6'b111111, 14'h3FF, k2);
    send(1'b0, 6'b000010, 14'h00B, k2);
    t = 0;
    while (inst_en[0] !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    chk("barrier_a_seen", 128'(inst_en[0]), 128'd1);
    status_sblk = 6'b000001;
    tick(10);
    status_sblk = '0;
    e = cyc;
    expect_issue(6'b000010, 14'h00B, e + 3);
    tick(10);

    // zero mask dropped with an error pulse, next command unaffected
    send(1'b0, 6'b000000, 14'h3FF, k);
    err_q.push_back(k + 1);
    send(1'b0, 6'b100000, 14'h077, k2);
    expect_issue(6'b100000, 14'h077, k2 + 2);
    tick(10);

    // reset during guard with three commands queued
    send(1'b0, 6'b000001, 14'h0C1, k);
    expect_issue(6'b000001, 14'h0C1, k + 2);
    send(1'b0, 6'b000010, 14'h0D2, k2);
    send(1'b0, 6'b000100, 14'h0E3, k2);
    send(1'b0, 6'b001000, 14'h0F4, k2);
    rst = 1'b1;
    #1;
    chk("midrst_inst_en", 128'(inst_en), 128'd0);
    chk("midrst_inst_data", 128'(inst_data), 128'd0);
    chk("midrst_busy", 128'(busy), 128'd0);
    chk("midrst_rdy", 128'(cmd_rdy), 128'd0);
    model = '0;
    last_iss = -1;
    tick(2);
    rst = 1'b0;
    tick(15);
    chk("post_rst_busy", 128'(busy), 128'd0);
    chk("post_rst_rdy", 128'(cmd_rdy), 128'd1);

    chk("iss_q_drained", 128'(iss_q.size()), 128'd0);
    chk("err_q_drained", 128'(err_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
